instr_fetch: RTL



---
 rtl/rv32_pkg.sv | 20 ++
 rtl/instr_fetch_if.sv | 41 ++++
 rtl/instr_fetch.sv | 92 +++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32i definitions: fetch FSM states, datapath widths, illegal-word helper.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int PC_W = 30;

    localparam logic [XLEN-1:0] ILLEGAL_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // Non-32-bit encodings and the all-zero word are never legal rv32i.
    function automatic logic is_illegal(input logic [XLEN-1:0] w);
        return (w[1:0] != 2'b11) || (w == ILLEGAL_ZERO);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC side, imem req/ack bus and decode valid/ready output.
// instr_illegal exists only when FETCH_ILLEGAL_CHECK_EN is defined.
interface instr_fetch_if;
    import rv32_pkg::*;

    logic [PC_W-1:0] pc_addr;
    logic            flush;
    logic            pc_adv;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr_data;
    logic [PC_W-1:0] instr_pc;
`ifdef FETCH_ILLEGAL_CHECK_EN
    logic            instr_illegal;
`endif

    modport master (
        input  pc_addr, flush, imem_ack, imem_rdata, instr_ready,
        output pc_adv, imem_req, imem_addr,
        output instr_valid, instr_data, instr_pc
`ifdef FETCH_ILLEGAL_CHECK_EN
        , output instr_illegal
`endif
    );

    modport slave (
        output pc_addr, flush, imem_ack, imem_rdata, instr_ready,
        input  pc_adv, imem_req, imem_addr,
        input  instr_valid, instr_data, instr_pc
`ifdef FETCH_ILLEGAL_CHECK_EN
        , input instr_illegal
`endif
    );

endinterface

// File: rtl/instr_fetch.sv
// rv32i fetch stage: IDLE/REQ/HOLD FSM between PC, imem and decode.
// Optional FETCH_ILLEGAL_CHECK_EN adds a registered instr_illegal flag.
module instr_fetch
    import rv32_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master fif
);

    fetch_state_t    r_state;
    fetch_state_t    w_next;
    logic [PC_W-1:0] r_addr;
    logic [PC_W-1:0] r_pc;
    logic [XLEN-1:0] r_data;
    logic            w_take;
    logic            w_req;
    logic            w_valid;
    logic            w_adv;

    always_comb begin
        w_next  = r_state;
        w_take  = 1'b0;
        w_req   = 1'b0;
        w_valid = 1'b0;
        w_adv   = 1'b0;
        case (r_state)
            IDLE: w_next = REQ;
            REQ: begin
                w_req = 1'b1;
                if (fif.imem_ack) begin
                    w_take = 1'b1;
                    w_next = HOLD;
                end
            end
            HOLD: begin
                w_valid = 1'b1;
                if (fif.instr_ready) begin
                    w_adv  = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        // A redirect or reset kills both the arriving word and the handoff.
        if (fif.flush || rst) begin
            w_next = IDLE;
            w_take = 1'b0;
            w_adv  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_pc    <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_addr <= fif.pc_addr;
            end
            if (w_take) begin
                r_data <= fif.imem_rdata;
                r_pc   <= r_addr;
            end
        end
    end

`ifdef FETCH_ILLEGAL_CHECK_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_take) begin
            r_illegal <= is_illegal(fif.imem_rdata);
        end
    end

    assign fif.instr_illegal = r_illegal;
`endif

    assign fif.imem_req    = w_req;
    assign fif.imem_addr   = r_addr;
    assign fif.pc_adv      = w_adv;
    assign fif.instr_valid = w_valid;
    assign fif.instr_data  = r_data;
    assign fif.instr_pc    = r_pc;

endmodule
